// File: rtl/io_out_fifo.sv
// Buffered output port behind the load_store core: a small FIFO that the core
// pushes into with a write strobe and an external consumer drains over valid/ready.
module io_out_fifo #(
    parameter int WIDTH  = 16,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic              clock,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [WIDTH-1:0]  wr_data,
    output logic              full,
    output logic              out_valid,
    output logic [WIDTH-1:0]  out_data,
    input  logic              out_ready,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    input  logic              ovf_clear
);

    localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              pop;
    logic              push;
    logic              drop;

    // Handshake: a word leaves when out_valid && out_ready at the rising edge;
    // a push is taken when wr_en and there is room, counting the slot freed by a
    // same-cycle pop. The core is never back-pressured; a refused push is dropped.
    assign out_valid = (count != '0);
    assign full      = (count == FULL_COUNT);
    assign pop       = out_valid && out_ready;
    assign push      = wr_en && (!full || pop);
    assign drop      = wr_en && full && !pop;
    assign out_data  = out_valid ? mem[rd_ptr] : '0;

    // Storage is deliberately left out of reset; out_data is masked when empty.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
            // A drop in the same cycle as a clear keeps the flag set.
            if (drop) begin
                overflow <= 1'b1;
            end else if (ovf_clear) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_io_out_fifo.sv
// Directed bench for io_out_fifo: a queue model predicts every popped word and
// the registered status after each clock.
module tb_io_out_fifo;

    localparam int WIDTH  = 16;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 2;

    logic              clock;
    logic              rst;
    logic              wr_en;
    logic [WIDTH-1:0]  wr_data;
    logic              full;
    logic              out_valid;
    logic [WIDTH-1:0]  out_data;
    logic              out_ready;
    logic [ADDR_W:0]   count;
    logic              overflow;
    logic              ovf_clear;

    logic [WIDTH-1:0]  exp_q[$];
    logic              exp_ovf;
    int                checks;
    int                errors;

    io_out_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clock     (clock),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .full      (full),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .count     (count),
        .overflow  (overflow),
        .ovf_clear (ovf_clear)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_status(input string tag);
        int n;
        logic [WIDTH-1:0] head;
        n    = exp_q.size();
        head = (n != 0) ? exp_q[0] : '0;
        check({tag, " count"},     32'(count),     32'(n));
        check({tag, " out_valid"}, 32'(out_valid), 32'(n != 0));
        check({tag, " full"},      32'(full),      32'(n == DEPTH));
        check({tag, " overflow"},  32'(overflow),  32'(exp_ovf));
        check({tag, " out_data"},  32'(out_data),  32'(head));
    endtask

    // One clock: drive inputs, predict with the queue model, clock, then check.
    task automatic cycle(input string tag, input logic wr, input logic [WIDTH-1:0] d,
                         input logic rdy, input logic clr);
        bit pop_m;
        bit push_m;
        wr_en     = wr;
        wr_data   = d;
        out_ready = rdy;
        ovf_clear = clr;
        pop_m  = (exp_q.size() != 0) && rdy;
        push_m = wr && ((exp_q.size() < DEPTH) || pop_m);
        if (pop_m) begin
            check({tag, " pop data"}, 32'(out_data), 32'(exp_q[0]));
            void'(exp_q.pop_front());
        end
        if (push_m) exp_q.push_back(d);
        if (wr && !push_m) exp_ovf = 1'b1;
        else if (clr)      exp_ovf = 1'b0;
        @(posedge clock);
        #1;
        wr_en     = 1'b0;
        ovf_clear = 1'b0;
        check_status(tag);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        exp_ovf   = 1'b0;
        rst       = 1'b0;
        wr_en     = 1'b0;
        wr_data   = '0;
        out_ready = 1'b0;
        ovf_clear = 1'b0;

        // Reset state
        repeat (2) @(posedge clock);
        #1;
        check_status("reset");
        #3 rst = 1'b1;

        // Three pushes with the consumer stalled
        cycle("push1", 1'b1, 16'h1111, 1'b0, 1'b0);
        cycle("push2", 1'b1, 16'h2222, 1'b0, 1'b0);
        cycle("push3", 1'b1, 16'h3333, 1'b0, 1'b0);
        check("three head", 32'(out_data), 32'h1111);
        for (int i = 0; i < 3; i++) cycle("drain1", 1'b0, '0, 1'b1, 1'b0);

        // Fill, overflow drop, drain, then clear
        for (int i = 0; i < 4; i++) cycle("fill_a", 1'b1, 16'hA000 + 16'(i), 1'b0, 1'b0);
        cycle("drop", 1'b1, 16'hBEEF, 1'b0, 1'b0);
        check("drop ovf", 32'(overflow), 32'h1);
        cycle("drop_vs_clear", 1'b1, 16'hDEAD, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) cycle("drain_a", 1'b0, '0, 1'b1, 1'b0);
        cycle("sticky", 1'b0, '0, 1'b1, 1'b0);
        cycle("ovf_clear", 1'b0, '0, 1'b0, 1'b1);

        // Full with simultaneous push and pop
        for (int i = 0; i < 4; i++) cycle("fill_b", 1'b1, 16'hB000 + 16'(i), 1'b0, 1'b0);
        cycle("full_pushpop", 1'b1, 16'h5555, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) cycle("drain_b", 1'b0, '0, 1'b1, 1'b0);

        // Wrap-around: streaming push and pop
        for (int i = 0; i < 10; i++) cycle("wrap", 1'b1, 16'(i), 1'b1, 1'b0);
        cycle("wrap_tail", 1'b0, '0, 1'b1, 1'b0);

        // Single word through an empty FIFO with ready held high
        cycle("idle_ready", 1'b0, '0, 1'b1, 1'b0);
        cycle("single_push", 1'b1, 16'h00C3, 1'b1, 1'b0);
        cycle("single_pop", 1'b0, '0, 1'b1, 1'b0);

        // Asynchronous reset with three words and overflow pending
        for (int i = 0; i < 4; i++) cycle("fill_c", 1'b1, 16'hC000 + 16'(i), 1'b0, 1'b0);
        cycle("drop_c", 1'b1, 16'hFFFF, 1'b0, 1'b0);
        cycle("pop_c", 1'b0, '0, 1'b1, 1'b0);
        out_ready = 1'b0;
        #2 rst = 1'b0;
        #1;
        exp_q.delete();
        exp_ovf = 1'b0;
        check_status("async_reset");
        #2 rst = 1'b1;
        cycle("post_reset", 1'b1, 16'h7777, 1'b0, 1'b0);
        cycle("post_drain", 1'b0, '0, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
